// File: rtl/vdg_pixel_shifter.sv
// Pixel serializer for character cells: latches one 8-bit pattern row plus its colours
// per cell and shifts it out MSB-first as a 4-bit colour index, one pixel per PixEn.
module vdg_pixel_shifter #(
    parameter int          PIXELS_PER_CHAR = 8,
    parameter logic [3:0]  SEMI_OFF_COLOUR = 4'd0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PixEn,
    input  logic       LineStart,
    input  logic       Active,
    input  logic       Semi,
    input  logic [7:0] SData,
    input  logic [3:0] SColour,
    input  logic [7:0] AData,
    input  logic [3:0] AFg,
    input  logic [3:0] ABg,
    input  logic [3:0] Border,
    output logic [3:0] Colour,
    output logic       CharLoad
);

    localparam int CW = (PIXELS_PER_CHAR > 1) ? $clog2(PIXELS_PER_CHAR) : 1;
    localparam logic [CW-1:0] LAST = CW'(PIXELS_PER_CHAR - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    fg_q, fg_d;
    logic [3:0]    bg_q, bg_d;
    logic          act_q, act_d;
    logic          semi_q, semi_d;
    logic [3:0]    colour_q, colour_d;
    logic          char_load_q, char_load_d;
    logic          load;

    assign load = PixEn && (LineStart || (cnt_q == LAST));

    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        act_d       = act_q;
        semi_d      = semi_q;
        colour_d    = colour_q;
        char_load_d = 1'b0;

        // Colour is built from the pre-edge register contents, so the first pixel
        // of a freshly loaded cell appears one enable after its load.
        if (PixEn) begin
            if (!act_q) begin
                colour_d = Border;
            end else begin
                colour_d = shift_q[7] ? fg_q : bg_q;
            end
        end

        if (load) begin
            cnt_d       = '0;
            shift_d     = Semi ? SData : AData;
            fg_d        = Semi ? SColour : AFg;
            bg_d        = Semi ? SEMI_OFF_COLOUR : ABg;
            act_d       = Active;
            semi_d      = Semi;
            char_load_d = 1'b1;
        end else if (PixEn) begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = {shift_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q       <= LAST;
            shift_q     <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            act_q       <= 1'b0;
            semi_q      <= 1'b0;
            colour_q    <= '0;
            char_load_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            act_q       <= act_d;
            semi_q      <= semi_d;
            colour_q    <= colour_d;
            char_load_q <= char_load_d;
        end
    end

    // Latched cell type is kept for observability only; pixel colours already encode it.
    logic unused_semi;
    assign unused_semi = semi_q;

    assign Colour   = colour_q;
    assign CharLoad = char_load_q;

endmodule

// File: doc/vdg_pixel_shifter.md
Name: vdg_pixel_shifter

Overview:
Pixel serializer directly downstream of the Semigraphics-6 pattern ROM and the alphanumeric character ROM. Once per character cell it latches an 8-bit pattern and its colour attributes. It then shifts the pattern out MSB-first, one pixel per dot-clock enable, as a 4-bit colour index for the palette/DAC stage. It also emits the per-cell load strobe that upstream address/row logic uses to advance to the next character.

Parameters:
PIXELS_PER_CHAR, 8, dot enables per character cell; range 2..8, patterns always 8 bits wide, MSB first
SEMI_OFF_COLOUR, 4'd0, colour index driven for a 0 bit in semigraphics mode (black)

Ports:
Clk  in  1  system clock; all state on rising edge
Reset  in  1  asynchronous, active-high reset
PixEn  in  1  dot-clock enable; state advances only when high
LineStart  in  1  start of active scan line; qualified by PixEn
Active  in  1  display-window flag from timing generator; sampled at cell load
Semi  in  1  1 = semigraphics cell, 0 = alphanumeric cell; sampled at cell load
SData  in  8  semigraphics pattern row
SColour  in  4  semigraphics foreground colour index
AData  in  8  alphanumeric glyph row, already inverted upstream if required
AFg  in  4  alphanumeric foreground colour index
ABg  in  4  alphanumeric background colour index
Border  in  4  border colour index; used live, not latched
Colour  out  4  registered pixel colour index
CharLoad  out  1  registered one-Clk strobe marking a cell load

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-high; no synchronous reset path.
- Reset values: Colour=0, CharLoad=0, shift register=0, latched fg/bg=0, latched active=0, latched semi=0, cell counter=PIXELS_PER_CHAR-1. The first PixEn after reset release therefore performs a load.
- With PixEn=0, every register holds, except CharLoad, which clears on every Clk where no load occurs. LineStart is ignored while PixEn=0.
- Load condition, evaluated on a Clk edge with PixEn=1: LineStart=1, or counter==PIXELS_PER_CHAR-1.
- On a load:
  - counter←0
  - shift←Semi ? SData : AData
  - fg←Semi ? SColour : AFg
  - bg←Semi ? SEMI_OFF_COLOUR : ABg
  - latched active←Active
  - CharLoad←1 for exactly that Clk
- On a non-load PixEn: counter+1; shift←{shift[6:0],1'b0}.
- LineStart mid-cell aborts the current cell and loads immediately. The remaining pixels of the aborted cell are never output.
- Colour update on every PixEn, computed from the values the register held before that edge:
  - latched active=0 → Border
  - otherwise shift[7] ? fg : bg
- Latency: the first pixel of a cell appears on Colour one PixEn after its load edge; pixel k (MSB=0) appears k+1 PixEn after load. The last pixel of a cell and the first pixel of the next cell are on consecutive PixEn, with no gap.
- Active deasserting mid-cell has no effect until the next load. Border follows its input live while latched active=0.
- Upstream must present SData/AData/colours valid on the PixEn following a CharLoad pulse (next-cell prefetch window = PIXELS_PER_CHAR-1 enables).
- Reset asserted mid-cell: immediate return to reset values; no partial pixels after release.
- Counter width is $clog2(PIXELS_PER_CHAR); it never exceeds PIXELS_PER_CHAR-1.

Test Plan:
- Reset, then PixEn every Clk, LineStart pulse, Active=1, Semi=1, SData=8'hF0, SColour=4'd5 → CharLoad on load cycle; Colour sequence 5,5,5,5,0,0,0,0; CharLoad repeats every 8 enables.
- Semi=0, AData=8'hA5, AFg=4'd2, ABg=4'd9 → Colour 2,9,2,9,9,2,9,2.
- Active=0 at load, Border=4'd3, SData=8'hFF → eight pixels of 3. Border changed to 4'd7 mid-cell → immediately 7. Active rising mid-cell → no effect until next CharLoad.
- PixEn every 4th Clk → Colour changes only on enable edges; CharLoad high exactly one Clk per 8 enables; outputs otherwise stable.
- LineStart on the 3rd pixel of a cell (SData=8'hFF then next SData=8'h00) → reload; Colour 5,5,5 then 0 from the next enable; counter restarts, next CharLoad 8 enables later.
- Reset pulse mid-cell → Colour=0, CharLoad=0 asynchronously. First PixEn after release loads (CharLoad=1); PIXELS_PER_CHAR=6 run gives a CharLoad every 6 enables, emitting SData[7:2] only.
